// File: rtl/ec_point_mult.sv
// Scalar multiply controller: k*P by right-to-left double-and-add over Jacobian points.
// Drives ec_point_add / ec_point_dbl through their point-level valid/ready ports.
package ec_point_mult_pkg;
  typedef logic [380:0] fe_t;
  typedef struct packed {
    fe_t x;
    fe_t y;
    fe_t z;
  } jb_point_t;
endpackage

// state | meaning
// IDLE  | waiting for a request
// CHECK | inspect K, decide add/dbl for the current bit
// ISSUE | present operands to adder/doubler until each handshakes
// WAIT  | collect outstanding results, then shift K
// DONE  | hold result until the consumer takes it
module ec_point_mult #(
  parameter type         FE_TYPE  = ec_point_mult_pkg::fe_t,
  parameter type         FP_TYPE  = ec_point_mult_pkg::jb_point_t,
  parameter int unsigned DAT_BITS = 381
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DAT_BITS-1:0]         i_k,
  input  logic [$bits(FP_TYPE)-1:0]   i_p,
  input  logic                        i_val,
  output logic                        o_rdy,
  output logic [$bits(FP_TYPE)-1:0]   o_p,
  output logic                        o_val,
  input  logic                        i_rdy,
  output logic                        o_err,
  output logic [$bits(FP_TYPE)-1:0]   o_add_p1,
  output logic [$bits(FP_TYPE)-1:0]   o_add_p2,
  output logic                        o_add_val,
  input  logic                        i_add_rdy,
  input  logic [$bits(FP_TYPE)-1:0]   i_add_p,
  input  logic                        i_add_val,
  output logic                        o_add_rdy,
  input  logic                        i_add_err,
  output logic [$bits(FP_TYPE)-1:0]   o_dbl_p,
  output logic                        o_dbl_val,
  input  logic                        i_dbl_rdy,
  input  logic [$bits(FP_TYPE)-1:0]   i_dbl_p,
  input  logic                        i_dbl_val,
  output logic                        o_dbl_rdy,
  input  logic                        i_dbl_err
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [DAT_BITS-1:0] k_q, k_d;
  FP_TYPE              q_q, q_d, r_q, r_d;
  logic                add_iss_q, add_iss_d, dbl_iss_q, dbl_iss_d;
  logic                add_pend_q, add_pend_d, dbl_pend_q, dbl_pend_d;
  logic                err_q, err_d;
  logic                do_add, do_dbl;

  function automatic FP_TYPE inf_point();
    FP_TYPE p;
    p   = '0;
    p.x = FE_TYPE'(1);
    p.y = FE_TYPE'(1);
    return p;
  endfunction

  // First set bit with R at infinity is a plain copy, so the adder never sees infinity.
  assign do_add = k_q[0] & (r_q.z != '0);
  assign do_dbl = (k_q >> 1) != '0;

  assign o_add_p1 = r_q;
  assign o_add_p2 = q_q;
  assign o_dbl_p  = q_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    q_d        = q_q;
    r_d        = r_q;
    add_iss_d  = add_iss_q;
    dbl_iss_d  = dbl_iss_q;
    add_pend_d = add_pend_q;
    dbl_pend_d = dbl_pend_q;
    err_d      = err_q;
    o_rdy      = 1'b0;
    o_p        = '0;
    o_val      = 1'b0;
    o_err      = 1'b0;
    o_add_val  = 1'b0;
    o_dbl_val  = 1'b0;
    o_add_rdy  = 1'b0;
    o_dbl_rdy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_rdy = ~i_rst;
        if (i_val) begin
          k_d     = i_k;
          q_d     = FP_TYPE'(i_p);
          r_d     = inf_point();
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (k_q == '0) begin
          state_d = DONE;
        end else begin
          if (k_q[0] && (r_q.z == '0)) r_d = q_q;
          add_iss_d  = do_add;
          add_pend_d = do_add;
          dbl_iss_d  = do_dbl;
          dbl_pend_d = do_dbl;
          if (do_add || do_dbl) begin
            state_d = ISSUE;
          end else begin
            k_d = k_q >> 1;
          end
        end
      end
      ISSUE: begin
        o_add_val = add_iss_q;
        o_dbl_val = dbl_iss_q;
        if (add_iss_q && i_add_rdy) add_iss_d = 1'b0;
        if (dbl_iss_q && i_dbl_rdy) dbl_iss_d = 1'b0;
        if (!add_iss_d && !dbl_iss_d) state_d = WAIT;
      end
      WAIT: begin
        o_add_rdy = add_pend_q;
        o_dbl_rdy = dbl_pend_q;
        if (add_pend_q && i_add_val) begin
          r_d        = FP_TYPE'(i_add_p);
          err_d      = err_d | i_add_err;
          add_pend_d = 1'b0;
        end
        if (dbl_pend_q && i_dbl_val) begin
          q_d        = FP_TYPE'(i_dbl_p);
          err_d      = err_d | i_dbl_err;
          dbl_pend_d = 1'b0;
        end
        if (!add_pend_d && !dbl_pend_d) begin
          k_d     = k_q >> 1;
          state_d = CHECK;
        end
      end
      DONE: begin
        o_p   = r_q;
        o_val = 1'b1;
        o_err = err_q;
        if (i_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      add_iss_q  <= 1'b0;
      dbl_iss_q  <= 1'b0;
      add_pend_q <= 1'b0;
      dbl_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      q_q        <= q_d;
      r_q        <= r_d;
      add_iss_q  <= add_iss_d;
      dbl_iss_q  <= dbl_iss_d;
      add_pend_q <= add_pend_d;
      dbl_pend_q <= dbl_pend_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_ec_point_mult.sv
// Bench for ec_point_mult: abstract adder/doubler models (points carry their multiple of G
// in x) with random stalls and latencies; results checked against k*G computed directly.
module tb_ec_point_mult;
  import ec_point_mult_pkg::*;
  localparam int PW = $bits(jb_point_t);

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [380:0] i_k;
  jb_point_t    i_p;
  logic         i_val, o_rdy, o_val, i_rdy, o_err;
  jb_point_t    o_p, o_add_p1, o_add_p2, i_add_p, o_dbl_p, i_dbl_p;
  logic         o_add_val, i_add_rdy, i_add_val, o_add_rdy, i_add_err;
  logic         o_dbl_val, i_dbl_rdy, i_dbl_val, o_dbl_rdy, i_dbl_err;

  int n_checks = 0;
  int n_fail   = 0;
  int add_cnt  = 0;
  int dbl_cnt  = 0;
  bit inj_add_err = 0;
  bit hold_dbl    = 0;
  bit flush       = 0;

  ec_point_mult dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_k(i_k), .i_p(i_p), .i_val(i_val), .o_rdy(o_rdy),
    .o_p(o_p), .o_val(o_val), .i_rdy(i_rdy), .o_err(o_err),
    .o_add_p1(o_add_p1), .o_add_p2(o_add_p2), .o_add_val(o_add_val), .i_add_rdy(i_add_rdy),
    .i_add_p(i_add_p), .i_add_val(i_add_val), .o_add_rdy(o_add_rdy), .i_add_err(i_add_err),
    .o_dbl_p(o_dbl_p), .o_dbl_val(o_dbl_val), .i_dbl_rdy(i_dbl_rdy),
    .i_dbl_p(i_dbl_p), .i_dbl_val(i_dbl_val), .o_dbl_rdy(o_dbl_rdy), .i_dbl_err(i_dbl_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  // k*G at the group level: x holds the multiple of G, y/z ride along unchanged.
  function automatic jb_point_t ref_mult(input logic [63:0] k, input jb_point_t g);
    jb_point_t r;
    if (k == 0) begin
      r.x = 1; r.y = 1; r.z = 0;
    end else begin
      r.x = fe_t'(k) * g.x; r.y = g.y; r.z = g.z;
    end
    return r;
  endfunction

  // Adder model: R+Q as a sum of multiples; R must be finite and a smaller multiple than Q.
  jb_point_t a_res;
  bit        a_busy = 0;
  int        a_del  = 0;
  initial begin
    forever begin
      @(negedge i_clk); #1;
      if (flush) begin
        a_busy = 0; i_add_val = 0; i_add_rdy = 0; i_add_err = 0;
      end else if (!a_busy) begin
        i_add_val = 0; i_add_err = 0;
        i_add_rdy = ($urandom_range(0, 3) != 0);
        if (o_add_val && i_add_rdy && !i_rst) begin
          check_eq("add operands", (o_add_p1.x < o_add_p2.x) && (o_add_p1.z != '0), 1);
          a_res.x = o_add_p1.x + o_add_p2.x;
          a_res.y = o_add_p1.y;
          a_res.z = o_add_p1.z;
          a_del   = $urandom_range(0, 3);
          a_busy  = 1;
          add_cnt++;
        end
      end else begin
        i_add_rdy = 0;
        if (a_del > 0) begin
          a_del--; i_add_val = 0;
        end else begin
          i_add_val = 1; i_add_p = a_res; i_add_err = inj_add_err;
          if (o_add_rdy && !i_rst) a_busy = 0;
        end
      end
    end
  end

  jb_point_t d_res;
  bit        d_busy = 0;
  int        d_del  = 0;
  initial begin
    forever begin
      @(negedge i_clk); #1;
      if (flush) begin
        d_busy = 0; i_dbl_val = 0; i_dbl_rdy = 0; i_dbl_err = 0;
      end else if (!d_busy) begin
        i_dbl_val = 0; i_dbl_err = 0;
        i_dbl_rdy = ($urandom_range(0, 3) != 0);
        if (o_dbl_val && i_dbl_rdy && !i_rst) begin
          d_res.x = o_dbl_p.x + o_dbl_p.x;
          d_res.y = o_dbl_p.y;
          d_res.z = o_dbl_p.z;
          d_del   = $urandom_range(0, 3);
          d_busy  = 1;
          dbl_cnt++;
        end
      end else begin
        i_dbl_rdy = 0;
        if (d_del > 0 || hold_dbl) begin
          if (d_del > 0) d_del--;
          i_dbl_val = 0;
        end else begin
          i_dbl_val = 1; i_dbl_p = d_res;
          if (o_dbl_rdy && !i_rst) d_busy = 0;
        end
      end
    end
  end

  task automatic submit(input logic [63:0] k, input jb_point_t gp);
    int cyc;
    @(negedge i_clk);
    i_k = '0; i_k[63:0] = k; i_p = gp; i_val = 1;
    cyc = 0;
    while (!o_rdy && cyc < 100) begin
      @(negedge i_clk); cyc++;
    end
    check_eq("accept ready", o_rdy, 1);
    @(negedge i_clk);
    i_val = 0;
  endtask

  task automatic run_job(input string tag, input logic [63:0] k, input jb_point_t gp,
                         input bit add_e, input int hold, input bit exp_err);
    jb_point_t exp_p;
    int        exp_add, exp_dbl, msb, cyc;
    exp_p = ref_mult(k, gp);
    msb = 0;
    for (int b = 0; b < 64; b++) if (k[b]) msb = b;
    exp_add = (k == 0) ? 0 : $countones(k) - 1;
    exp_dbl = (k == 0) ? 0 : msb;
    inj_add_err = add_e;
    add_cnt = 0; dbl_cnt = 0;
    submit(k, gp);
    cyc = 1;
    while (!o_val && cyc < 3000) begin
      @(negedge i_clk); cyc++;
    end
    check_eq({tag, " o_val"}, o_val, 1);
    if (k == 0) check_eq({tag, " latency<=4"}, cyc <= 4, 1);
    for (int h = 0; h < hold; h++) begin
      check_eq({tag, " stall o_p"}, o_p, exp_p);
      check_eq({tag, " stall o_val/o_rdy"}, {o_val, o_rdy}, 2'b10);
      @(negedge i_clk);
    end
    check_eq({tag, " o_p"}, o_p, exp_p);
    check_eq({tag, " o_err"}, o_err, exp_err);
    check_eq({tag, " add count"}, add_cnt, exp_add);
    check_eq({tag, " dbl count"}, dbl_cnt, exp_dbl);
    i_rdy = 1;
    @(negedge i_clk);
    i_rdy = 0;
    check_eq({tag, " back to idle"}, {o_rdy, o_val}, 2'b10);
    inj_add_err = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  jb_point_t g, rg;
  int        cyc;
  initial begin
    g.x = 7; g.y = 'h1234; g.z = 'h55;
    i_rst = 1; i_val = 0; i_rdy = 0; i_k = '0; i_p = '0;
    i_add_val = 0; i_add_rdy = 0; i_add_err = 0; i_add_p = '0;
    i_dbl_val = 0; i_dbl_rdy = 0; i_dbl_err = 0; i_dbl_p = '0;
    repeat (3) @(negedge i_clk);
    check_eq("reset outputs", {o_rdy, o_val, o_err, o_add_val, o_dbl_val, o_add_rdy, o_dbl_rdy}, 0);
    check_eq("reset o_p", o_p, 0);
    i_rst = 0;
    @(negedge i_clk);
    check_eq("idle o_rdy", o_rdy, 1);

    run_job("k0", 64'd0, g, 0, 0, 0);
    run_job("k1", 64'd1, g, 0, 0, 0);
    run_job("k2", 64'd2, g, 0, 0, 0);
    run_job("k3", 64'd3, g, 0, 0, 0);
    run_job("kB", 64'hB, g, 0, 2, 0);
    run_job("k5 add err", 64'd5, g, 1, 0, 1);
    run_job("k2 err cleared", 64'd2, g, 0, 0, 0);
    run_job("done stall", 64'd6, g, 0, 10, 0);
    for (int j = 0; j < 6; j++) begin
      rg.x = $urandom_range(1, 1000); rg.y = $urandom; rg.z = $urandom | 1;
      run_job("random", 64'($urandom_range(1, 65535)), rg, 0, $urandom_range(0, 3), 0);
    end

    // Abort a job while the doubler result is outstanding; the late result must be refused.
    hold_dbl = 1;
    submit(64'hFF, g);
    cyc = 0;
    while (!o_dbl_rdy && cyc < 200) begin
      @(negedge i_clk); cyc++;
    end
    check_eq("reached WAIT", o_dbl_rdy, 1);
    i_rst = 1;
    @(negedge i_clk);
    check_eq("mid-job reset outputs",
             {o_rdy, o_val, o_err, o_add_val, o_dbl_val, o_add_rdy, o_dbl_rdy}, 0);
    check_eq("mid-job reset o_p", o_p, 0);
    i_rst = 0; hold_dbl = 0;
    repeat (6) begin
      @(negedge i_clk);
      check_eq("late dbl ignored", {o_dbl_rdy, o_rdy, o_val}, 3'b010);
    end
    flush = 1;
    @(negedge i_clk);
    @(negedge i_clk);
    flush = 0;
    run_job("k3 after abort", 64'd3, g, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ec_point_mult.md
Name: ec_point_mult

Overview:
- Scalar-multiplication controller: computes k·P for a Jacobian point P by right-to-left double-and-add.
- Sits directly upstream of ec_point_add and ec_point_dbl; drives their point-level valid/ready ports and consumes their results.
- Field-op units (mult/add/sub) stay attached to the adder/doubler; this block does no field arithmetic.

Parameters:
- FP_TYPE, jb_point_t, Jacobian point struct {x,y,z} of FE_TYPE.
- FE_TYPE, fe_t, field-element type.
- DAT_BITS, 381, scalar width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_k  in  DAT_BITS  scalar
- i_p  in  $bits(FP_TYPE)  base point
- i_val  in  1  request valid
- o_rdy  out  1  request accepted when i_val&o_rdy
- o_p  out  $bits(FP_TYPE)  result k·P
- o_val  out  1  result valid
- i_rdy  in  1  result consumer ready
- o_err  out  1  sticky error for this job, valid with o_val
- o_add_p1, o_add_p2  out  $bits(FP_TYPE) each  adder operands (R, Q)
- o_add_val  out  1;  i_add_rdy  in  1
- i_add_p  in  $bits(FP_TYPE);  i_add_val  in  1;  o_add_rdy  out  1;  i_add_err  in  1
- o_dbl_p  out  $bits(FP_TYPE);  o_dbl_val  out  1;  i_dbl_rdy  in  1
- i_dbl_p  in  $bits(FP_TYPE);  i_dbl_val  in  1;  o_dbl_rdy  out  1;  i_dbl_err  in  1

Behaviour:
- One clock i_clk; reset is synchronous, active-high (i_rst).
- Reset: state=IDLE, o_rdy=0 during reset then 1 in IDLE, o_val=0, o_err=0, o_add_val=0, o_dbl_val=0, o_add_rdy=0, o_dbl_rdy=0, o_p=0. Reset mid-job aborts; in-flight adder/doubler results arriving later are discarded (o_*_rdy=1 only in WAIT).
- Infinity: any point with z==0. R initialised to infinity (x=1,y=1,z=0).
- Registers: K (shift reg), Q (point), R (point), flags add_pend/dbl_pend, err.
- IDLE: o_rdy=1. On i_val&o_rdy: K<=i_k, Q<=i_p, R<=inf, err<=0 → CHECK. o_rdy=0 outside IDLE.
- CHECK (1 cycle): if K==0 → DONE. Else do_add = K[0] & (R.z!=0); if K[0] & R.z==0 then R<=Q (no adder use). do_dbl = (K>>1)!=0. Go ISSUE if do_add|do_dbl, else shift K and return to CHECK.
- ISSUE: assert o_add_val (operands R,Q) if do_add and o_dbl_val (operand Q) if do_dbl, concurrently; each held stable until its own rdy; each drops the cycle after its handshake. When all issued handshakes complete → WAIT.
- WAIT: o_add_rdy=add_pend, o_dbl_rdy=dbl_pend. On i_add_val&o_add_rdy: R<=i_add_p, err|=i_add_err. On i_dbl_val&o_dbl_rdy: Q<=i_dbl_p, err|=i_dbl_err. Results may arrive in either order or same cycle. When both pend flags clear: K<=K>>1 → CHECK.
- DONE: o_p=R, o_val=1, o_err=err; held stable until i_rdy; on handshake → IDLE (o_rdy=1 next cycle).
- Scalar must be < group order r (guarantees R≠Q at every add); no R==Q detection.
- Early termination at K==0: op count = popcount(k)-1 adds, floor(log2 k) doubles.
- Unexpected result (i_*_val while not pending) is never accepted (rdy low).

Test Plan:
- k=0, P=g_point → o_p.z==0, o_err=0, zero o_add_val/o_dbl_val pulses, o_val within 4 cycles of accept.
- k=1, P=g_point → o_p==g_point, no add or dbl requests issued.
- k=2 → one dbl, zero add; o_p==dbl_jb_point(g_point).
- k=3 → one dbl, one add (add operands R=g, Q=g, wait — R=g, Q=2g concurrently issued); o_p==add_jb_point(g_point, dbl_jb_point(g_point)); also k=0xB vs software model with adder/doubler models returning results in random order and random rdy stalls.
- i_add_err pulsed on one result of k=5 → o_err=1 with o_val; next job k=2 → o_err=0.
- i_rdy held 0 for 10 cycles at DONE → o_p/o_val stable, o_rdy=0; i_rst asserted mid-WAIT for k=0xFF → all outputs at reset values next cycle, late i_dbl_val ignored, following k=3 job correct.
